// File: rtl/output_byte_packer.sv
// Packs a stream of int8 results into little-endian 32-bit words and issues
// strobed word writes to output tensor RAM, one job (base, length) at a time.
module output_byte_packer #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_bytes,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_byte_cnt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_word_idx;
  logic [1:0]        r_lane;
  logic [31:0]       r_pack;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic [3:0]        r_wr_strb;

  logic [LEN_W-1:0]  w_cnt_inc;
  logic              w_last;
  logic              w_complete;
  logic              w_out_held;
  logic              w_can_take;
  logic              w_accept;
  logic [31:0]       w_word;
  logic [3:0]        w_strb;

  assign w_cnt_inc  = r_byte_cnt + LEN_W'(1);
  assign w_last     = (w_cnt_inc == r_len);
  assign w_complete = (r_lane == 2'd3) || w_last;
  assign w_out_held = r_wr_valid && !wr_ready;
  // A completing byte needs the output register free (or retiring this cycle).
  assign w_can_take = !(w_complete && w_out_held);
  assign w_accept   = in_valid && in_ready;

  // Current byte merged into its lane; lanes above it are still zero in r_pack.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_word[8*gi +: 8] = (r_lane == 2'(gi)) ? in_data : r_pack[8*gi +: 8];
      assign w_strb[gi]        = (2'(gi) <= r_lane);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (num_bytes == '0) ? S_DONE : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        busy     = 1'b1;
        in_ready = w_can_take;
        if (in_valid && w_can_take && w_last) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_wr_valid && wr_ready) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_base     <= '0;
      r_word_idx <= '0;
      r_lane     <= '0;
      r_pack     <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_strb  <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_len      <= num_bytes;
        r_base     <= base_addr;
        r_byte_cnt <= '0;
        r_word_idx <= '0;
        r_lane     <= '0;
        r_pack     <= '0;
      end
      if (r_wr_valid && wr_ready) begin
        r_wr_valid <= 1'b0;
      end
      // A load on the same edge as a retire overrides the clear: no bubble.
      if (w_accept) begin
        r_byte_cnt <= w_cnt_inc;
        r_lane     <= r_lane + 2'd1;
        if (w_complete) begin
          r_wr_valid <= 1'b1;
          r_wr_addr  <= r_base + r_word_idx;
          r_wr_data  <= w_word;
          r_wr_strb  <= w_strb;
          r_word_idx <= r_word_idx + ADDR_W'(1);
          r_pack     <= '0;
        end else begin
          r_pack <= w_word;
        end
      end
    end
  end

  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign wr_strb  = r_wr_strb;

endmodule
